// File: rtl/rfphoenix_alu_sched_if.sv
// Requester and writeback bus for rfphoenix_alu_sched.
// Operand slot order inside req_opnd is a, b, c, t, imm (index 0..4).
interface rfphoenix_alu_sched_if #(
    parameter int NREQ = 4,
    parameter int TAGW = $clog2(NREQ),
    parameter int IW   = 32,
    parameter int AW   = 16
);
    logic [NREQ-1:0]                req;
    logic [NREQ-1:0][IW-1:0]        req_ir;
    logic [NREQ-1:0][4:0][31:0]     req_opnd;
    logic [NREQ-1:0][AW-1:0]        req_asid;
    logic [NREQ-1:0]                gnt;

    logic                           res_v;
    logic                           res_rdy;
    logic [31:0]                    res_o;
    logic [TAGW-1:0]                res_tag;

    // master: thread issue / writeback side; slave: the scheduler
    modport master (
        output req, req_ir, req_opnd, req_asid, res_rdy,
        input  gnt, res_v, res_o, res_tag
    );

    modport slave (
        input  req, req_ir, req_opnd, req_asid, res_rdy,
        output gnt, res_v, res_o, res_tag
    );
endinterface

// File: rtl/rfphoenix_alu_sched.sv
// Round-robin scheduler for a shared combinational ALU: issue register -> ALU -> result register.
// Optional macro RFP_ALU_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module rfphoenix_alu_sched #(
    parameter int NREQ = 4,
    parameter int TAGW = $clog2(NREQ),
    parameter int IW   = 32,
    parameter int AW   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    rfphoenix_alu_sched_if.slave  bus,
    input  logic [31:0]           hmask,
    output logic [IW-1:0]         alu_ir,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [31:0]           alu_c,
    output logic [31:0]           alu_t,
    output logic [31:0]           alu_imm,
    output logic [AW-1:0]         alu_asid,
    output logic [31:0]           alu_hmask,
    input  logic [31:0]           alu_o,
    input  logic                  flush,
    input  logic [TAGW-1:0]       flush_tag
);

    // Issue stage (s1) state
    logic                  s1_v_q,   s1_v_d;
    logic [TAGW-1:0]       s1_tag_q, s1_tag_d;
    logic [IW-1:0]         ir_q,     ir_d;
    logic [4:0][31:0]      opnd_q,   opnd_d;
    logic [AW-1:0]         asid_q,   asid_d;

    // Result stage (s2) state
    logic                  s2_v_q,   s2_v_d;
    logic [31:0]           res_o_q,  res_o_d;
    logic [TAGW-1:0]       res_tag_q, res_tag_d;

    logic [TAGW-1:0]       rr_ptr_q, rr_ptr_d;

    logic                  s1_kill, s2_kill;
    logic                  s1_eff, s2_eff;
    logic                  s1_acc, s2_acc;
    logic [NREQ-1:0]       elig;
    logic [NREQ-1:0]       elig_rr;
    logic [NREQ-1:0]       gnt_c;
    logic                  gnt_any;
    logic                  prio_hit;
    logic [TAGW-1:0]       gnt_idx;
    logic [TAGW-1:0]       idx;

    // A stage hit by flush is treated as already empty this cycle.
    always_comb begin
        s1_kill = flush && s1_v_q && (s1_tag_q == flush_tag);
        s2_kill = flush && s2_v_q && (res_tag_q == flush_tag);
        s1_eff  = s1_v_q && !s1_kill;
        s2_eff  = s2_v_q && !s2_kill;
        s2_acc  = !s2_eff || bus.res_rdy;
        s1_acc  = !s1_eff || s2_acc;
    end

    // Grant selection: flushed tag is masked out before the search.
    always_comb begin
        elig = bus.req;
        if (flush) elig[flush_tag] = 1'b0;
        gnt_c    = '0;
        gnt_any  = 1'b0;
        prio_hit = 1'b0;
        gnt_idx  = '0;
        idx      = '0;
`ifdef RFP_ALU_PRIO0_EN
        elig_rr = elig & ~NREQ'(1);
        if (s1_acc && elig[0]) begin
            gnt_c[0] = 1'b1;
            gnt_any  = 1'b1;
            prio_hit = 1'b1;
        end
`else
        elig_rr = elig;
`endif
        for (int i = 0; i < NREQ; i++) begin
            idx = TAGW'((int'(rr_ptr_q) + i) % NREQ);
            if (s1_acc && !gnt_any && elig_rr[idx]) begin
                gnt_c[idx] = 1'b1;
                gnt_any    = 1'b1;
                gnt_idx    = idx;
            end
        end
        if (rst) begin
            gnt_c   = '0;
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        s1_v_d    = s1_v_q;
        s1_tag_d  = s1_tag_q;
        ir_d      = ir_q;
        opnd_d    = opnd_q;
        asid_d    = asid_q;
        s2_v_d    = s2_v_q;
        res_o_d   = res_o_q;
        res_tag_d = res_tag_q;

        if (gnt_any) begin
            s1_v_d   = 1'b1;
            s1_tag_d = gnt_idx;
            ir_d     = bus.req_ir[gnt_idx];
            opnd_d   = bus.req_opnd[gnt_idx];
            asid_d   = bus.req_asid[gnt_idx];
            // A priority grant to requester 0 leaves the round-robin pointer alone.
            if (!prio_hit)
                rr_ptr_d = (gnt_idx == TAGW'(NREQ - 1)) ? '0 : gnt_idx + TAGW'(1);
        end else if (s1_acc) begin
            s1_v_d = 1'b0;
        end

        if (s1_eff && s2_acc) begin
            s2_v_d    = 1'b1;
            res_o_d   = alu_o;
            res_tag_d = s1_tag_q;
        end else if (s2_acc) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_tag_q  <= '0;
            ir_q      <= '0;
            opnd_q    <= '0;
            asid_q    <= '0;
            s2_v_q    <= 1'b0;
            res_o_q   <= '0;
            res_tag_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_tag_q  <= s1_tag_d;
            ir_q      <= ir_d;
            opnd_q    <= opnd_d;
            asid_q    <= asid_d;
            s2_v_q    <= s2_v_d;
            res_o_q   <= res_o_d;
            res_tag_q <= res_tag_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // A flushed result is withdrawn in the same cycle so writeback never sees it.
    assign bus.gnt     = gnt_c;
    assign bus.res_v   = s2_v_q && !s2_kill;
    assign bus.res_o   = res_o_q;
    assign bus.res_tag = res_tag_q;

    assign alu_ir    = ir_q;
    assign alu_a     = opnd_q[0];
    assign alu_b     = opnd_q[1];
    assign alu_c     = opnd_q[2];
    assign alu_t     = opnd_q[3];
    assign alu_imm   = opnd_q[4];
    assign alu_asid  = asid_q;
    assign alu_hmask = hmask;

endmodule

// File: tb/tb_rfphoenix_alu_sched.sv
// Directed bench for rfphoenix_alu_sched with a small combinational ALU model.
module tb_rfphoenix_alu_sched;
    localparam int NREQ = 4;
    localparam int TAGW = 2;
    localparam logic [31:0] OP_ADDI = 32'h13;
    localparam logic [31:0] OP_HASH = 32'h33;
    localparam logic [31:0] OP_SUM  = 32'h0B;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] hmask;
    logic [31:0] alu_ir, alu_a, alu_b, alu_c, alu_t, alu_imm, alu_hmask, alu_o;
    logic [15:0] alu_asid;
    logic flush;
    logic [TAGW-1:0] flush_tag;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rfphoenix_alu_sched_if #(.NREQ(NREQ), .TAGW(TAGW), .IW(32), .AW(16)) bus ();

    rfphoenix_alu_sched #(.NREQ(NREQ), .TAGW(TAGW), .IW(32), .AW(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .hmask(hmask),
        .alu_ir(alu_ir), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_t(alu_t),
        .alu_imm(alu_imm), .alu_asid(alu_asid), .alu_hmask(alu_hmask), .alu_o(alu_o),
        .flush(flush), .flush_tag(flush_tag)
    );

    always_comb begin
        alu_o = 32'h0;
        if (alu_ir == OP_ADDI)      alu_o = alu_a + alu_imm;
        else if (alu_ir == OP_HASH) alu_o = (alu_a ^ alu_b) & alu_hmask;
        else if (alu_ir == OP_SUM)  alu_o = alu_c + alu_t + {16'h0, alu_asid};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [31:0] ir, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm);
        bus.req_ir[r]      = ir;
        bus.req_opnd[r][0] = a;
        bus.req_opnd[r][1] = b;
        bus.req_opnd[r][2] = 32'h0;
        bus.req_opnd[r][3] = 32'h0;
        bus.req_opnd[r][4] = imm;
        bus.req_asid[r]    = 16'(r);
    endtask

    // Requester r computes 10*r + 1.
    task automatic std_ops();
        for (int r = 0; r < NREQ; r++) set_op(r, OP_ADDI, 32'(10 * r), 32'h0, 32'h1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        flush = 1'b0;
        flush_tag = '0;
        bus.res_rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'hF;
        bus.res_rdy = 1'b1;
        flush = 1'b0;
        flush_tag = '0;
        hmask = 32'hFFFF_FFFF;
        std_ops();
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
            checks++; if (bus.res_v !== 1'b0) begin errors++; $display("FAIL reset_res_v: got %b expected 0", bus.res_v); end
            checks++; if (bus.res_o !== 32'h0) begin errors++; $display("FAIL reset_res_o: got %h expected 0", bus.res_o); end
        end
        checks++; if (alu_a !== 32'h0 || bus.res_tag !== 2'd0) begin errors++; $display("FAIL reset_regs: alu_a %h res_tag %0d expected 0/0", alu_a, bus.res_tag); end
        rst = 1'b0;
        bus.req = '0;
        tick();
    endtask

    task automatic test_single_op();
        do_reset();
        std_ops();
        set_op(2, OP_ADDI, 32'd5, 32'h0, 32'd7);
        bus.req = 4'b0100;
        #1;
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", bus.gnt); end
        tick();
        bus.req = '0;
        #1;
        checks++; if (bus.res_v !== 1'b0) begin errors++; $display("FAIL single_early: res_v got %b expected 0", bus.res_v); end
        tick();
        checks++; if (bus.res_v !== 1'b1 || bus.res_o !== 32'd12 || bus.res_tag !== 2'd2) begin
            errors++; $display("FAIL single_res: got v=%b o=%0d tag=%0d expected v=1 o=12 tag=2", bus.res_v, bus.res_o, bus.res_tag); end
        tick();
        checks++; if (bus.res_v !== 1'b0) begin errors++; $display("FAIL single_retire: res_v got %b expected 0", bus.res_v); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        int t;
        do_reset();
        std_ops();
        bus.req = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_g = 4'(1 << (i % 4));
            checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL fair_gnt%0d: got %b expected %b", i, bus.gnt, exp_g); end
            if (i >= 2) begin
                t = (i - 2) % 4;
                checks++; if (bus.res_v !== 1'b1 || bus.res_tag !== 2'(t) || bus.res_o !== 32'(10 * t + 1)) begin
                    errors++; $display("FAIL fair_res%0d: got v=%b tag=%0d o=%0d expected v=1 tag=%0d o=%0d", i, bus.res_v, bus.res_tag, bus.res_o, t, 10 * t + 1); end
            end
            tick();
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        std_ops();
        bus.req = 4'hF;
        #1;
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL bp_gnt0: got %b expected 0001", bus.gnt); end
        tick();
        #1;
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL bp_gnt1: got %b expected 0010", bus.gnt); end
        tick();
        bus.res_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL bp_stall_gnt%0d: got %b expected 0000", k, bus.gnt); end
            checks++; if (bus.res_v !== 1'b1 || bus.res_o !== 32'd1 || bus.res_tag !== 2'd0) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b o=%0d tag=%0d expected v=1 o=1 tag=0", k, bus.res_v, bus.res_o, bus.res_tag); end
            tick();
        end
        bus.req = '0;
        bus.res_rdy = 1'b1;
        #1;
        checks++; if (bus.res_v !== 1'b1 || bus.res_tag !== 2'd0 || bus.res_o !== 32'd1) begin
            errors++; $display("FAIL bp_drain0: got v=%b tag=%0d o=%0d expected v=1 tag=0 o=1", bus.res_v, bus.res_tag, bus.res_o); end
        tick();
        checks++; if (bus.res_v !== 1'b1 || bus.res_tag !== 2'd1 || bus.res_o !== 32'd11) begin
            errors++; $display("FAIL bp_drain1: got v=%b tag=%0d o=%0d expected v=1 tag=1 o=11", bus.res_v, bus.res_tag, bus.res_o); end
        tick();
        checks++; if (bus.res_v !== 1'b0) begin errors++; $display("FAIL bp_empty: res_v got %b expected 0", bus.res_v); end
        bus.req = 4'hF;
        #1;
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL bp_resume: got %b expected 0100", bus.gnt); end
        bus.req = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        std_ops();
        bus.req = 4'b1000;
        #1;
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL flush_gnt3: got %b expected 1000", bus.gnt); end
        tick();
        bus.req = 4'b0010;
        #1;
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL flush_gnt1: got %b expected 0010", bus.gnt); end
        tick();
        flush = 1'b1;
        flush_tag = 2'd1;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL flush_suppress: got %b expected 0000", bus.gnt); end
        checks++; if (bus.res_v !== 1'b1 || bus.res_tag !== 2'd3 || bus.res_o !== 32'd31) begin
            errors++; $display("FAIL flush_keep3: got v=%b tag=%0d o=%0d expected v=1 tag=3 o=31", bus.res_v, bus.res_tag, bus.res_o); end
        tick();
        flush = 1'b0;
        bus.req = '0;
        #1;
        checks++; if (bus.res_v !== 1'b0) begin errors++; $display("FAIL flush_kill1a: res_v got %b tag %0d expected 0", bus.res_v, bus.res_tag); end
        tick();
        checks++; if (bus.res_v !== 1'b0) begin errors++; $display("FAIL flush_kill1b: res_v got %b expected 0", bus.res_v); end
        // Kill a result while writeback is ready for it.
        bus.req = 4'b0100;
        #1;
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL flush_gnt2: got %b expected 0100", bus.gnt); end
        tick();
        bus.req = '0;
        tick();
        flush = 1'b1;
        flush_tag = 2'd2;
        #1;
        checks++; if (bus.res_v !== 1'b0) begin errors++; $display("FAIL flush_s2_drop: res_v got %b expected 0", bus.res_v); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (bus.res_v !== 1'b0) begin errors++; $display("FAIL flush_s2_gone: res_v got %b expected 0", bus.res_v); end
    endtask

    task automatic test_flush_skip();
        do_reset();
        std_ops();
        bus.req = 4'b0011;
        flush = 1'b1;
        flush_tag = 2'd0;
        #1;
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL skip_gnt: got %b expected 0010", bus.gnt); end
        tick();
        flush = 1'b0;
        bus.req = '0;
        tick();
        checks++; if (bus.res_v !== 1'b1 || bus.res_tag !== 2'd1 || bus.res_o !== 32'd11) begin
            errors++; $display("FAIL skip_res: got v=%b tag=%0d o=%0d expected v=1 tag=1 o=11", bus.res_v, bus.res_tag, bus.res_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        std_ops();
        bus.req = 4'b0001;
        #1;
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL rmid_gnt: got %b expected 0001", bus.gnt); end
        tick();
        bus.req = '0;
        rst = 1'b1;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rmid_gnt_rst: got %b expected 0000", bus.gnt); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.res_v !== 1'b0) begin errors++; $display("FAIL rmid_res0: res_v got %b expected 0", bus.res_v); end
        tick();
        checks++; if (bus.res_v !== 1'b0) begin errors++; $display("FAIL rmid_res1: res_v got %b expected 0", bus.res_v); end
    endtask

    task automatic test_hmask();
        do_reset();
        std_ops();
        hmask = 32'hFFFF_FFFF;
        set_op(0, OP_HASH, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0);
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        hmask = 32'h0000_FF00;
        tick();
        checks++; if (bus.res_v !== 1'b1 || bus.res_o !== 32'h0000_F000) begin
            errors++; $display("FAIL hmask_live: got v=%b o=%h expected v=1 o=0000f000", bus.res_v, bus.res_o); end
        hmask = 32'hFFFF_FFFF;
        tick();
    endtask

    task automatic test_prio0();
        logic [3:0] exp_g;
        do_reset();
        std_ops();
        bus.req = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL prio_gnt%0d: got %b expected 0001", i, bus.gnt); end
            tick();
        end
        bus.req = 4'hE;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp_g = 4'(2 << i);
            checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL prio_rr%0d: got %b expected %b", i, bus.gnt, exp_g); end
            tick();
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    initial begin
        bus.req = '0;
        bus.res_rdy = 1'b1;
        std_ops();
        test_reset();
        test_single_op();
`ifdef RFP_ALU_PRIO0_EN
        test_prio0();
`else
        test_fairness();
        test_backpressure();
        test_flush();
`endif
        test_flush_skip();
        test_reset_mid();
        test_hmask();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
